// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller for the MSX video block: control/data port decode,
// auto-incrementing VRAM access with read-ahead, VDP registers, status and interrupt.
module vdp_port_ctrl #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_a,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_busy,
  output logic [13:0] vram_addr,
  output logic        vram_wr,
  output logic        vram_rd,
  output logic [7:0]  vram_dout,
  input  logic [7:0]  vram_din,
  input  logic        frame_tick,
  input  logic        collision_in,
  input  logic        fifth_in,
  input  logic [4:0]  fifth_num,
  output logic [1:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic        video_on,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic        vert_retrace_int,
  output logic        n_int
);

  localparam int unsigned AW = 14;
  localparam int unsigned CW = 2;

  typedef enum logic {S_IDLE, S_LATCHED} state_t;

  state_t          r_state;
  logic [7:0]      r_reg [0:7];
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_latch;
  logic [7:0]      r_rbuf;
  logic            r_f;
  logic            r_5s;
  logic            r_c;
  logic [4:0]      r_num;
  logic [CW-1:0]   r_cnt;

  logic            w_wr;
  logic            w_rd;
  logic            w_data_wr;
  logic            w_data_rd;
  logic            w_ctrl_wr;
  logic            w_stat_rd;
  logic [7:0]      w_status;
  logic [AW-1:0]   w_setup_addr;
  logic [AW-1:0]   w_addr_inc;
  logic            w_mode2;
  logic            w_unused;

  // A write strobe wins over a simultaneous read; data-port accesses are dropped while busy
  assign w_wr         = cpu_wr;
  assign w_rd         = cpu_rd & ~cpu_wr;
  assign w_data_wr    = w_wr & ~cpu_a & ~cpu_busy;
  assign w_data_rd    = w_rd & ~cpu_a & ~cpu_busy;
  assign w_ctrl_wr    = w_wr & cpu_a;
  assign w_stat_rd    = w_rd & cpu_a;
  assign w_status     = {r_f, r_5s, r_c, (r_5s ? r_num : 5'h1F)};
  assign w_setup_addr = {cpu_din[5:0], r_latch};
  assign w_addr_inc   = r_addr + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < 8; i++) r_reg[i] <= 8'h00;
      r_addr    <= '0;
      r_latch   <= 8'h00;
      r_rbuf    <= 8'h00;
      r_f       <= 1'b0;
      r_5s      <= 1'b0;
      r_c       <= 1'b0;
      r_num     <= 5'h00;
      r_cnt     <= '0;
      cpu_dout  <= 8'h00;
      cpu_busy  <= 1'b0;
      vram_addr <= '0;
      vram_wr   <= 1'b0;
      vram_rd   <= 1'b0;
      vram_dout <= 8'h00;
    end else begin
      vram_wr <= 1'b0;
      vram_rd <= 1'b0;

      // Sticky status flags: a set event beats the clear-on-read
      r_f  <= frame_tick   | (r_f  & ~w_stat_rd);
      r_c  <= collision_in | (r_c  & ~w_stat_rd);
      r_5s <= fifth_in     | (r_5s & ~w_stat_rd);
      if (fifth_in && (!r_5s || w_stat_rd)) r_num <= fifth_num;

      if (cpu_busy) begin
        if (r_cnt == '0) begin
          r_rbuf   <= vram_din;
          cpu_busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end

      if (w_stat_rd) begin
        cpu_dout <= w_status;
        r_state  <= S_IDLE;
      end else if (w_data_rd) begin
        cpu_dout  <= r_rbuf;
        r_state   <= S_IDLE;
        vram_rd   <= 1'b1;
        vram_addr <= r_addr;
        r_addr    <= w_addr_inc;
        cpu_busy  <= 1'b1;
        r_cnt     <= CW'(READ_LATENCY);
      end else if (w_data_wr) begin
        r_state   <= S_IDLE;
        vram_wr   <= 1'b1;
        vram_addr <= r_addr;
        vram_dout <= cpu_din;
        r_rbuf    <= cpu_din;
        r_addr    <= w_addr_inc;
      end else if (w_ctrl_wr) begin
        if (r_state == S_IDLE) begin
          r_latch <= cpu_din;
          r_state <= S_LATCHED;
        end else begin
          r_state <= S_IDLE;
          if (cpu_din[7]) begin
            r_reg[cpu_din[2:0]] <= r_latch;
          end else if (cpu_din[6]) begin
            r_addr <= w_setup_addr;
          end else begin
            vram_rd   <= 1'b1;
            vram_addr <= w_setup_addr;
            r_addr    <= w_setup_addr + AW'(1);
            cpu_busy  <= 1'b1;
            r_cnt     <= CW'(READ_LATENCY);
          end
        end
      end
    end
  end

  // Register decode into video block configuration
  assign w_mode2 = (mode == 2'd2);
  assign mode = r_reg[1][4] ? 2'd0 :
                r_reg[1][3] ? 2'd3 :
                r_reg[0][1] ? 2'd2 : 2'd1;
  assign name_table_addr           = {r_reg[2][3:0], 10'b0};
  assign color_table_addr          = w_mode2 ? {r_reg[3][7], 13'b0} : {r_reg[3], 6'b0};
  assign font_addr                 = w_mode2 ? {r_reg[4][2], 13'b0} : {r_reg[4][2:0], 11'b0};
  assign sprite_attr_addr          = {r_reg[5][6:0], 7'b0};
  assign sprite_pattern_table_addr = {r_reg[6][2:0], 11'b0};
  assign text_color                = r_reg[7][7:4];
  assign back_color                = r_reg[7][3:0];
  assign video_on                  = r_reg[1][6];
  assign sprite_large              = r_reg[1][1];
  assign sprite_enlarged           = r_reg[1][0];
  assign vert_retrace_int          = r_reg[1][5];
  assign n_int                     = ~(r_f & r_reg[1][5]);

  assign w_unused = ^{r_reg[0][7:2], r_reg[0][0], r_reg[1][7], r_reg[1][2],
                      r_reg[2][7:4], r_reg[4][7:3], r_reg[5][7], r_reg[6][7:3]};

endmodule

// File: doc/vdp_port_ctrl.md
Name: vdp_port_ctrl

Overview:
- CPU-side controller for the MSX video block: decodes VDP I/O port accesses (data port and control port).
- Sequences CPU VRAM reads and writes through an auto-incrementing address with a read-ahead buffer.
- Holds VDP registers R0–R7 and decodes them into the video block's mode, table-address, colour and sprite configuration inputs.
- Owns the status register and the frame interrupt line.

Parameters:
READ_LATENCY, 1, clk cycles from vram_rd to valid vram_din (1..3)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cpu_rd  in  1  single-cycle read strobe
cpu_wr  in  1  single-cycle write strobe
cpu_a  in  1  0 = data port, 1 = control port
cpu_din  in  8  write data
cpu_dout  out  8  read data, registered
cpu_busy  out  1  read-ahead pending
vram_addr  out  14  VRAM address
vram_wr  out  1  VRAM write pulse
vram_rd  out  1  VRAM read pulse
vram_dout  out  8  VRAM write data
vram_din  in  8  VRAM read data
frame_tick  in  1  one-cycle pulse per frame at vertical retrace
collision_in  in  1  sprite collision from video
fifth_in  in  1  too-many-sprites from video
fifth_num  in  5  sprite number of 5th sprite
mode  out  2  0 text, 1 graphics1, 2 graphics2, 3 multicolour
name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr  out  14 each  table bases
text_color, back_color  out  4 each  from R7[7:4] / R7[3:0]
video_on, sprite_large, sprite_enlarged, vert_retrace_int  out  1 each
n_int  out  1  active-low interrupt

Behaviour:
- Reset: R0–R7 = 0, address = 0, latch flag = 0, read buffer = 0, status = 0, cpu_dout = 0, cpu_busy = 0, vram_wr = vram_rd = 0, n_int = 1.
  - Decoded outputs at reset: mode = 1, video_on = 0, all table bases = 0.
- Control-port write state machine, two states:
  - IDLE: byte goes to latch → LATCHED.
  - LATCHED, second byte bit7 = 1: R[d[2:0]] <= latch → IDLE.
  - LATCHED, second byte bit7 = 0: address <= {d[5:0], latch} → IDLE.
    - If d[6] = 0, issue a read-ahead; d[6] = 1 (write setup) issues none.
- Any data-port access or status read forces IDLE.
- Data write:
  - vram_wr pulse one cycle after the strobe: vram_addr = address, vram_dout = cpu_din.
  - Read buffer <= cpu_din; address increments.
- Data read:
  - cpu_dout <= read buffer on the cycle after the strobe, then issue a read-ahead.
- Read-ahead:
  - vram_rd pulse at the current address; address increments in the same cycle.
  - cpu_busy is high from the pulse until vram_din is captured into the read buffer READ_LATENCY cycles later.
  - A data-port access while cpu_busy is dropped; all outputs stay unchanged.
- Address is 14 bits and wraps 0x3FFF → 0x0000.
- Register decode:
  - video_on = R1[6]; IE = R1[5]; sprite_large = R1[1]; sprite_enlarged = R1[0]; vert_retrace_int = IE.
  - mode: M1 = R1[4] → 0; else M2 = R1[3] → 3; else M3 = R0[1] → 2; else 1.
  - name_table_addr = {R2[3:0], 10'b0}.
  - color_table_addr = {R3, 6'b0}; in mode 2 = {R3[7], 13'b0}.
  - font_addr = {R4[2:0], 11'b0}; in mode 2 = {R4[2], 13'b0}.
  - sprite_attr_addr = {R5[6:0], 7'b0}.
  - sprite_pattern_table_addr = {R6[2:0], 11'b0}.
- Status register = {F, 5S, C, number[4:0]}:
  - F set by frame_tick; C set by collision_in (sticky).
  - 5S set by fifth_in, loading fifth_num only while 5S = 0; number = 0x1F when 5S is clear.
  - Status read: cpu_dout <= status, then F, 5S and C clear. A set event in the same cycle wins.
- n_int = !(F & IE), combinational from registers.
- Simultaneous cpu_rd and cpu_wr: write is taken and read ignored.

Test Plan:
1. Write ctrl 0x00, 0x40, then data 0xAA, 0x55 → vram_wr at 0x0000 and 0x0001 with 0xAA, 0x55; address = 0x0002.
2. Preload VRAM[0x1234] = 0x5A, [0x1235] = 0xA5; write ctrl 0x34, 0x12, wait !cpu_busy, read data twice → 0x5A then 0xA5; vram_rd at 0x1234, 0x1235, 0x1236.
3. Write ctrl 0x10, 0x81 (R1 = 0x10) → mode = 0; R0 = 0x02, R1 = 0x00 → mode = 2; R3 = 0xFF → color_table_addr = 0x2000; R7 = 0xF4 → text_color = 15, back_color = 4.
4. Address 0x3FFF, write data twice → second write at 0x0000.
5. Write ctrl 0x60, 0x81 (IE = 1, video_on = 1), pulse frame_tick → n_int = 0; status read returns bit7 = 1, then n_int = 1; frame_tick coinciding with the read leaves F = 1.
6. fifth_in with fifth_num = 7, then fifth_num = 9 → status reads 0x47; after the read the status number reads 0x1F. Single control write then a status read → next control write is treated as a first byte.
